// File: rtl/data_memory.sv
// Byte-addressable 64-bit data memory: combinational loads, edge-committed stores.
// Define DMEM_FAULT_EN to enable alignment/range checking and the sticky fault flag.
module data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata,
    output logic        misaligned,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [63:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [2:0]    size_mask;
    logic [7:0]    base_be;
    logic [2:0]    lane;
    logic          bad;
    logic [63:0]   rd_word;
    logic [63:0]   rd_shift;
    logic [63:0]   wr_shift;
    logic [7:0]    be;
    logic          sx;

    assign idx = addr[AW+2:3];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        size_mask = 3'b000;
        base_be   = 8'h01;
        unique case (funct3[1:0])
            2'b00: begin size_mask = 3'b000; base_be = 8'h01; end
            2'b01: begin size_mask = 3'b001; base_be = 8'h03; end
            2'b10: begin size_mask = 3'b011; base_be = 8'h0F; end
            2'b11: begin size_mask = 3'b111; base_be = 8'hFF; end
        endcase
    end

`ifdef DMEM_FAULT_EN
    logic aligned;
    logic in_range;

    assign aligned    = (addr[2:0] & size_mask) == 3'b000;
    assign in_range   = addr[63:AW+3] == '0;
    assign bad        = (mem_read | mem_write) & ~(aligned & in_range);
    assign lane       = addr[2:0];
    assign misaligned = bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault <= 1'b0;
        else if (bad)
            fault <= 1'b1;
    end
`else
    // Upper address bits are ignored: the word index wraps and accesses are forced aligned.
    logic unused_addr_hi;

    assign unused_addr_hi = ^addr[63:AW+3];
    assign bad            = 1'b0;
    assign lane           = addr[2:0] & ~size_mask;
    assign misaligned     = 1'b0;
    assign fault          = 1'b0;
`endif

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};
    assign wr_shift = wdata << {lane, 3'b000};
    assign be       = base_be << lane;
    assign sx       = ~funct3[2];

    always_comb begin
        rdata = '0;
        if (mem_read && !bad) begin
            unique case (funct3[1:0])
                2'b00: rdata = {{56{sx & rd_shift[7]}},  rd_shift[7:0]};
                2'b01: rdata = {{48{sx & rd_shift[15]}}, rd_shift[15:0]};
                2'b10: rdata = {{32{sx & rd_shift[31]}}, rd_shift[31:0]};
                2'b11: rdata = rd_word;
            endcase
        end
    end

    // Only the addressed byte lanes are written; the rest of the word is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (mem_write && !bad) begin
            for (int b = 0; b < 8; b++)
                if (be[b])
                    mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random accesses
// compared against a byte-array reference model.
module tb_data_memory;

    localparam int DEPTH = 16;
    localparam int NBYTES = DEPTH * 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [63:0] rdata;
    logic        misaligned;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_bytes [NBYTES];
    logic       m_fault;

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .rdata(rdata), .misaligned(misaligned), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_bad(input logic [63:0] a, input logic [2:0] f3);
`ifdef DMEM_FAULT_EN
        return (a % 64'(nbytes(f3)) != 0) || (a >= 64'(NBYTES));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff_addr(input logic [63:0] a, input logic [2:0] f3);
`ifdef DMEM_FAULT_EN
        return int'(a);
`else
        logic [63:0] al;
        al = a - (a % 64'(nbytes(f3)));
        return int'(al % 64'(NBYTES));
`endif
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
        logic [63:0] v;
        int n, ea;
        n  = nbytes(f3);
        ea = eff_addr(a, f3);
        v  = '0;
        for (int i = 0; i < n; i++)
            v = v | (64'(m_bytes[ea + i]) << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input logic [63:0] a, input logic [63:0] d, input logic [2:0] f3);
        int ea;
        ea = eff_addr(a, f3);
        for (int i = 0; i < nbytes(f3); i++)
            m_bytes[ea + i] = d[8*i +: 8];
    endtask

    task automatic model_reset();
        for (int i = 0; i < NBYTES; i++)
            m_bytes[i] = 8'h00;
        m_fault = 1'b0;
    endtask

    // One full cycle: drive at negedge, check combinational outputs, commit at posedge, check fault.
    task automatic access(input bit rd, input bit wr, input logic [63:0] a,
                          input logic [63:0] d, input logic [2:0] f3, output logic [63:0] got);
        logic [63:0] exp_rd;
        bit bad;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d; funct3 = f3;
        #1;
        bad    = is_bad(a, f3) && (rd || wr);
        exp_rd = (rd && !bad) ? model_load(a, f3) : 64'd0;
        check("rdata", rdata, exp_rd);
        check("misaligned", {63'd0, misaligned}, {63'd0, bad});
        got = rdata;
        @(posedge clk);
        if (rst_n) begin
            if (bad) m_fault = 1'b1;
            else if (wr) model_store(a, d, f3);
        end
        #1;
        check("fault", {63'd0, fault}, {63'd0, m_fault});
    endtask

    task automatic idle();
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        model_reset();
        #1;
        check("reset_fault", {63'd0, fault}, 64'd0);
        check("reset_rdata", rdata, 64'd0);
        #12 rst_n = 1'b1;

        access(0, 1, 64'h10, 64'h8877665544332211, 3'b011, got);
        access(1, 0, 64'h10, 64'h0, 3'b011, got);
        check("ld_0x10", got, 64'h8877665544332211);
        access(1, 0, 64'h17, 64'h0, 3'b000, got);
        check("lb_0x17", got, 64'hFFFFFFFFFFFFFF88);
        access(1, 0, 64'h17, 64'h0, 3'b100, got);
        check("lbu_0x17", got, 64'h88);
        access(1, 0, 64'h12, 64'h0, 3'b001, got);
        check("lh_0x12", got, 64'h4433);
        access(1, 0, 64'h14, 64'h0, 3'b010, got);
        check("lw_0x14", got, 64'hFFFFFFFF88776655);
        access(1, 0, 64'h14, 64'h0, 3'b110, got);
        check("lwu_0x14", got, 64'h88776655);
        access(1, 0, 64'h10, 64'h0, 3'b111, got);
        check("f3_111_as_ld", got, 64'h8877665544332211);
        access(0, 1, 64'h11, 64'hAB, 3'b000, got);
        access(1, 0, 64'h10, 64'h0, 3'b011, got);
        check("sb_merge", got, 64'h887766554433AB11);

`ifdef DMEM_FAULT_EN
        access(0, 1, 64'h13, 64'hFFFFFFFF, 3'b010, got);
        check("sw_mis_fault", {63'd0, fault}, 64'd1);
        repeat (10) idle();
        check("fault_sticky", {63'd0, fault}, 64'd1);
        access(1, 0, 64'h10, 64'h0, 3'b011, got);
        check("sw_mis_unchanged", got, 64'h887766554433AB11);
        access(1, 0, 64'(NBYTES), 64'h0, 3'b011, got);
        check("ld_oob_rdata", got, 64'd0);
`endif

        access(1, 1, 64'h20, 64'h5, 3'b011, got);
        check("ldsd_old", got, 64'd0);
        access(1, 0, 64'h20, 64'h0, 3'b011, got);
        check("ldsd_new", got, 64'h5);

        for (int k = 0; k < 400; k++) begin
            logic [63:0] a;
            if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
            else                           a = 64'($urandom_range(0, NBYTES - 1));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   {$urandom, $urandom}, 3'($urandom_range(0, 7)), got);
        end

        // Asynchronous reset between edges, with a store attempted while held.
        access(0, 1, 64'h10, 64'h0123456789ABCDEF, 3'b011, got);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; addr = 64'h10; funct3 = 3'b011;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_fault", {63'd0, fault}, 64'd0);
        check("rst_ld_0x10", rdata, 64'd0);
        mem_read = 1'b0; mem_write = 1'b1; addr = 64'h18; wdata = 64'hDEAD; funct3 = 3'b011;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        #2 rst_n = 1'b1;
        access(1, 0, 64'h18, 64'h0, 3'b011, got);
        check("rst_sd_dropped", got, 64'd0);
        access(1, 0, 64'h10, 64'h0, 3'b011, got);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
